mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256, SHALL set the number of 32-bit RAM words (power of two).
REQ-002 Parameter GPIO_RESET, default 8'h00, SHALL set the GPIO register value after reset.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port write_enable  input  3  SHALL carry the store size: 3'b100 byte, 3'b010 half, 3'b001 word, 3'b000 read or idle.
REQ-006 Port addr  input  32  SHALL be the byte address from the core.
REQ-007 Port data_in  input  32  SHALL be the store data, right-aligned (the byte in [7:0], the half in [15:0]).
REQ-008 Port data_out  output  32  SHALL be the registered read data, right-aligned.
REQ-009 Port gpio  output  `MAX_GPIO+1  SHALL be driven by the GPIO register.

Function
REQ-010 The address map SHALL be:
- RAM: 0x0000_0000 to RAM_WORDS*4-1
- GPIO: 0x8000_0000, R/W
- CYCLE: 0x8000_0004, RO
- TCMP: 0x8000_0008, R/W
- TSTAT: 0x8000_000C, bit0 sticky match flag, write-1-to-clear
REQ-011 Register decode SHALL use addr[31:4] == 28'h8000000 and addr[3:2]; RAM decode SHALL use addr[31:2] < RAM_WORDS.
REQ-012 Reads SHALL be latency 1: data_out at edge N+1 reflects addr and memory state sampled at edge N.
REQ-013 The read word SHALL be shifted right by 8*addr[1:0] and zero-filled on the left, so the addressed byte lands in [7:0].
REQ-014 A byte store SHALL write data_in[7:0] to lane addr[1:0] only.
REQ-015 A half store SHALL write data_in[15:0] to lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored.
REQ-016 A word store SHALL write all four lanes; addr[1:0] is ignored.
REQ-017 A store SHALL take effect on every edge where write_enable is valid; repeated identical stores (write_enable held for several cycles) SHALL be idempotent.
REQ-018 A write_enable value with more than one bit set SHALL be ignored (no write), and the read SHALL proceed normally.
REQ-019 A read of an unmapped address SHALL return 0; a write to an unmapped address SHALL be discarded.
REQ-020 A read and a write to the same location on the same edge SHALL return the old data (read-before-write).
REQ-021 CYCLE SHALL increment by 1 every edge, wrap from 0xFFFF_FFFF to 0, and ignore writes.
REQ-022 Sub-word stores to GPIO, TCMP or TSTAT SHALL apply only to the addressed lanes; GPIO uses bits [`MAX_GPIO:0], upper bits read 0.
REQ-023 TSTAT bit0 SHALL set on the edge where CYCLE == TCMP.
REQ-024 If a match and a write-1-clear of TSTAT bit0 occur on the same edge, the set SHALL win.
REQ-025 TSTAT bits [31:1] SHALL read 0.

Reset
REQ-026 On rst high at an edge, SHALL load: data_out = 0, GPIO = GPIO_RESET, CYCLE = 0, TCMP = 0xFFFF_FFFF, TSTAT = 0.
REQ-027 Reset SHALL NOT clear RAM contents; RAM initialises to zero at configuration only.
REQ-028 A store presented on the same edge as rst SHALL be discarded for registers; the RAM write SHALL also be suppressed.
REQ-029 Reset asserted mid-sequence SHALL take priority over any pending count, match or write.

Structure
REQ-030 Region bases, register offsets and the write_enable encodings SHALL live in the shared header alongside config.vh and instructions.vh, for use by both the core and this block.
REQ-031 RAM storage SHALL be one sub-module, ram_bytelane: four 8-bit-wide arrays with per-lane write enables and a registered read, so it infers block RAM.
REQ-032 mem_responder SHALL contain the address decode, lane-enable generation, register file, read alignment and read mux.

Verification
REQ-033 Word/byte store: SW 0xDEADBEEF @0x10, then SB 0x55 @0x12, then read @0x10 -> data_out = 0xDE55BEEF one cycle after addr.
REQ-034 Misaligned read: read @0x13 after REQ-033 -> 0x000000DE; SH 0x1234 @0x11 (addr[0] ignored), then read @0x10 -> 0xDE551234.
REQ-035 GPIO and illegal enable: SW 0x1A5 @0x8000_0000 -> gpio = 0xA5 and read = 0x000000A5; write_enable = 3'b011 @0x8000_0000 -> gpio unchanged.
REQ-036 Timer: after reset write TCMP = 20 -> TSTAT reads 1 after CYCLE reaches 20; hold a W1C of 1 on the match edge -> flag stays 1; clear on a later edge -> flag reads 0.
REQ-037 Wrap: force CYCLE to 0xFFFF_FFFE -> reads 0xFFFF_FFFF then 0 on successive cycles.
REQ-038 Reset/unmapped: write GPIO = 0xFF, then assert rst -> gpio = GPIO_RESET, RAM @0x10 retained; read @0x4000_0000 -> 0; write there -> no state change.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared address map, store-size encodings and lane helpers for the core-side
// memory responder; imported by the responder and by the core.
package mem_responder_pkg;

    localparam int MAX_GPIO = 7;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [27:0] REG_PAGE    = 28'h800_0000;
    localparam logic [31:0] GPIO_ADDR   = 32'h8000_0000;
    localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0004;
    localparam logic [31:0] TCMP_ADDR   = 32'h8000_0008;
    localparam logic [31:0] TSTAT_ADDR  = 32'h8000_000C;

    typedef enum logic [1:0] {
        REG_GPIO  = 2'd0,
        REG_CYCLE = 2'd1,
        REG_TCMP  = 2'd2,
        REG_TSTAT = 2'd3
    } reg_idx_e;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_WORD = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_BYTE = 3'b100;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_REG
    } rd_sel_e;

    // Illegal encodings (several bits set) yield an empty mask, i.e. no write.
    function automatic logic [3:0] lane_mask(input logic [2:0] we, input logic [1:0] a);
        logic [3:0] m;
        case (we)
            WE_BYTE: m = 4'(4'b0001 << a);
            WE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            WE_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data so every lane sees its bytes.
    function automatic logic [31:0] align_store(input logic [2:0] we, input logic [31:0] d);
        logic [31:0] w;
        case (we)
            WE_BYTE: w = {4{d[7:0]}};
            WE_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-to-memory bus: store size, byte address, store data and read data.
interface mem_responder_if;
    logic [2:0]  write_enable;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output write_enable, addr, data_in, input data_out);
    modport slave  (input write_enable, addr, data_in, output data_out);
endinterface

// File: rtl/mem_responder_ram_bytelane.sv
// Byte-lane RAM: four 8-bit arrays with per-lane write enables and a
// registered read that returns the pre-write contents on a collision.
module ram_bytelane #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] q;

        // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
        always_ff @(posedge clk) begin
            if (we[l])
                mem[addr] <= wdata[8*l +: 8];
            q <= mem[addr];
        end

        assign rdata[8*l +: 8] = q;
    end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: RAM plus GPIO / free-running cycle counter / compare timer
// registers behind one latency-1 byte-addressed bus.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                RAM_WORDS  = 256,
    parameter logic [MAX_GPIO:0] GPIO_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    mem_responder_if.slave    bus,
    output logic [MAX_GPIO:0] gpio
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam logic [31:0] GPIO_MASK = {{(31-MAX_GPIO){1'b0}}, {(MAX_GPIO+1){1'b1}}};

    logic        ram_hit, reg_hit;
    reg_idx_e    reg_idx;
    logic [3:0]  lanes, ram_we, gpio_we, tcmp_we;
    logic [31:0] wdata, ram_rdata, reg_rdata, rd_word;
    logic        tstat_clr;

    logic [31:0] gpio_q, cycle_q, tcmp_q, reg_rdata_q;
    logic        tstat_q;
    rd_sel_e     rd_sel_q;
    logic [1:0]  rd_shift_q;

    assign ram_hit = bus.addr[31:2] < 30'(RAM_WORDS);
    assign reg_hit = bus.addr[31:4] == REG_PAGE;
    assign reg_idx = reg_idx_e'(bus.addr[3:2]);
    assign lanes   = lane_mask(bus.write_enable, bus.addr[1:0]);
    assign wdata   = align_store(bus.write_enable, bus.data_in);
    assign ram_we  = (ram_hit && !rst) ? lanes : 4'b0000;

    ram_bytelane #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .addr  (bus.addr[AW+1:2]),
        .we    (ram_we),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gpio_we   = '0;
        tcmp_we   = '0;
        tstat_clr = 1'b0;
        reg_rdata = '0;
        if (reg_hit) begin
            case (reg_idx)
                REG_GPIO:  gpio_we   = lanes;
                REG_TCMP:  tcmp_we   = lanes;
                REG_TSTAT: tstat_clr = lanes[0] & wdata[0];
                default:   ;
            endcase
        end
        case (reg_idx)
            REG_GPIO:  reg_rdata = gpio_q;
            REG_CYCLE: reg_rdata = cycle_q;
            REG_TCMP:  reg_rdata = tcmp_q;
            REG_TSTAT: reg_rdata = {31'b0, tstat_q};
            default:   reg_rdata = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q      <= 32'(GPIO_RESET);
            cycle_q     <= '0;
            tcmp_q      <= '1;
            tstat_q     <= 1'b0;
            reg_rdata_q <= '0;
            rd_sel_q    <= SEL_NONE;
            rd_shift_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            gpio_q  <= merge_lanes(gpio_q, wdata, gpio_we) & GPIO_MASK;
            tcmp_q  <= merge_lanes(tcmp_q, wdata, tcmp_we);
            // A match on the same edge as a clear keeps the flag set.
            if (cycle_q == tcmp_q)
                tstat_q <= 1'b1;
            else if (tstat_clr)
                tstat_q <= 1'b0;
            reg_rdata_q <= reg_rdata;
            rd_sel_q    <= ram_hit ? SEL_RAM : (reg_hit ? SEL_REG : SEL_NONE);
            rd_shift_q  <= bus.addr[1:0];
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_sel_q)
            SEL_RAM: rd_word = ram_rdata;
            SEL_REG: rd_word = reg_rdata_q;
            default: rd_word = '0;
        endcase
        bus.data_out = rd_word >> {rd_shift_q, 3'b000};
    end

    assign gpio = gpio_q[MAX_GPIO:0];

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboarded reads plus direct gpio checks.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam logic [7:0] GPIO_RST = 8'h3C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpio;
    int         checks   = 0;
    int         failures = 0;
    logic [31:0] cyc_model;
    logic [31:0] rst_dout;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    string       tag_q[$];

    mem_responder_if bus();

    mem_responder #(.RAM_WORDS(256), .GPIO_RESET(GPIO_RST)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .gpio (gpio)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc_model <= '0;
        else     cyc_model <= cyc_model + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one bus cycle from a negedge; returns at the next negedge.
    task automatic bus_cycle(input logic [2:0] we, input logic [31:0] a, input logic [31:0] d,
                             input bit chk, input logic [31:0] want, input string tag);
        bus.write_enable = we;
        bus.addr         = a;
        bus.data_in      = d;
        if (chk) begin
            exp_q.push_back(want);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        if (chk) obs_q.push_back(bus.data_out);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input logic [2:0] we, input logic [31:0] a, input logic [31:0] d);
        rst              = 1'b1;
        bus.write_enable = we;
        bus.addr         = a;
        bus.data_in      = d;
        @(posedge clk);
        #1;
        rst_dout = bus.data_out;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset(WE_WORD, GPIO_ADDR, 32'h11);
        checks++;
        if (rst_dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_data_out: got %h want %h", rst_dout, 32'h0);
        end
        checks++;
        if (gpio !== GPIO_RST) begin
            failures++;
            $display("FAIL reset_gpio: got %h want %h", gpio, GPIO_RST);
        end
        bus_cycle(WE_NONE, TCMP_ADDR,  0, 1, 32'hFFFF_FFFF, "reset_tcmp");
        bus_cycle(WE_NONE, TSTAT_ADDR, 0, 1, 32'h0, "reset_tstat");
        bus_cycle(WE_NONE, GPIO_ADDR,  0, 1, 32'(GPIO_RST), "reset_gpio_read");
        bus_cycle(WE_NONE, CYCLE_ADDR, 0, 1, cyc_model, "reset_cycle");
        while (exp_q.size() > 0) begin
            logic [31:0] want, got;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: data_out=%h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_ram_store();
        bus_cycle(WE_WORD, 32'h10, 32'hDEAD_BEEF, 0, 0, "");
        bus_cycle(WE_BYTE, 32'h12, 32'hFFFF_FF55, 0, 0, "");
        bus_cycle(WE_NONE, 32'h10, 0, 1, 32'hDE55_BEEF, "sw_sb_read");
        bus_cycle(WE_NONE, 32'h13, 0, 1, 32'h0000_00DE, "misaligned_13");
        bus_cycle(WE_HALF, 32'h11, 32'hFFFF_1234, 0, 0, "");
        bus_cycle(WE_NONE, 32'h10, 0, 1, 32'hDE55_1234, "sh_read");
        bus_cycle(WE_NONE, 32'h12, 0, 1, 32'h0000_DE55, "misaligned_12");
        bus_cycle(WE_WORD, 32'h10, 32'hCAFE_F00D, 1, 32'hDE55_1234, "read_before_write");
        bus_cycle(WE_NONE, 32'h10, 0, 1, 32'hCAFE_F00D, "after_rbw");
        bus_cycle(WE_BYTE, 32'h11, 32'h77, 1, 32'h00CA_FEF0, "held_sb_1");
        bus_cycle(WE_BYTE, 32'h11, 32'h77, 1, 32'h00CA_FE77, "held_sb_2");
        bus_cycle(WE_NONE, 32'h10, 0, 1, 32'hCAFE_770D, "held_sb_result");
        while (exp_q.size() > 0) begin
            logic [31:0] want, got;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: data_out=%h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_ram_bounds();
        bus_cycle(WE_WORD, 32'h000, 32'h1111_1111, 0, 0, "");
        bus_cycle(WE_WORD, 32'h3FC, 32'hA5A5_5A5A, 0, 0, "");
        bus_cycle(WE_WORD, 32'h400, 32'h9999_9999, 1, 32'h0, "unmapped_400_read");
        bus_cycle(WE_NONE, 32'h000, 0, 1, 32'h1111_1111, "no_alias_at_0");
        bus_cycle(WE_NONE, 32'h3FC, 0, 1, 32'hA5A5_5A5A, "last_word");
        bus_cycle(3'b111,  32'h3FC, 32'h0, 1, 32'hA5A5_5A5A, "illegal_we_read");
        bus_cycle(WE_NONE, 32'h3FC, 0, 1, 32'hA5A5_5A5A, "illegal_we_nowrite");
        while (exp_q.size() > 0) begin
            logic [31:0] want, got;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: data_out=%h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_registers();
        bus_cycle(WE_WORD, GPIO_ADDR, 32'h1A5, 0, 0, "");
        checks++;
        if (gpio !== 8'hA5) begin
            failures++;
            $display("FAIL gpio_sw: got %h want %h", gpio, 8'hA5);
        end
        bus_cycle(WE_NONE, GPIO_ADDR, 0, 1, 32'hA5, "gpio_read");
        bus_cycle(3'b011, GPIO_ADDR, 32'h3C, 1, 32'hA5, "gpio_illegal_read");
        checks++;
        if (gpio !== 8'hA5) begin
            failures++;
            $display("FAIL gpio_illegal_we: got %h want %h", gpio, 8'hA5);
        end
        bus_cycle(WE_BYTE, GPIO_ADDR + 32'd1, 32'h77, 0, 0, "");
        checks++;
        if (gpio !== 8'hA5) begin
            failures++;
            $display("FAIL gpio_upper_lane: got %h want %h", gpio, 8'hA5);
        end
        bus_cycle(WE_BYTE, GPIO_ADDR, 32'h5A, 0, 0, "");
        checks++;
        if (gpio !== 8'h5A) begin
            failures++;
            $display("FAIL gpio_sb: got %h want %h", gpio, 8'h5A);
        end
        bus_cycle(WE_NONE, GPIO_ADDR + 32'd3, 0, 1, 32'h0, "gpio_upper_read");
        bus_cycle(WE_HALF, TCMP_ADDR + 32'd2, 32'hBEEF, 0, 0, "");
        bus_cycle(WE_NONE, TCMP_ADDR, 0, 1, 32'hBEEF_FFFF, "tcmp_sh");
        bus_cycle(WE_WORD, CYCLE_ADDR, 32'h0001_2345, 0, 0, "");
        bus_cycle(WE_NONE, CYCLE_ADDR, 0, 1, cyc_model, "cycle_ignores_write");
        bus_cycle(WE_NONE, 32'h8000_0010, 0, 1, 32'h0, "past_reg_page");
        while (exp_q.size() > 0) begin
            logic [31:0] want, got;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: data_out=%h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_reset_retention();
        bus_cycle(WE_WORD, GPIO_ADDR, 32'hFF, 0, 0, "");
        bus_cycle(WE_WORD, 32'h20, 32'h1234_5678, 0, 0, "");
        checks++;
        if (gpio !== 8'hFF) begin
            failures++;
            $display("FAIL gpio_ff: got %h want %h", gpio, 8'hFF);
        end
        pulse_reset(WE_WORD, 32'h20, 32'hAAAA_AAAA);
        checks++;
        if (gpio !== GPIO_RST) begin
            failures++;
            $display("FAIL retention_gpio: got %h want %h", gpio, GPIO_RST);
        end
        checks++;
        if (rst_dout !== 32'h0) begin
            failures++;
            $display("FAIL retention_data_out: got %h want %h", rst_dout, 32'h0);
        end
        bus_cycle(WE_NONE, 32'h20, 0, 1, 32'h1234_5678, "ram_write_on_rst_dropped");
        bus_cycle(WE_NONE, 32'h10, 0, 1, 32'hCAFE_770D, "ram_retained");
        bus_cycle(WE_NONE, 32'h4000_0000, 0, 1, 32'h0, "unmapped_read");
        bus_cycle(WE_WORD, 32'h4000_0000, 32'hFFFF_FFFF, 0, 0, "");
        bus_cycle(WE_NONE, GPIO_ADDR, 0, 1, 32'(GPIO_RST), "unmapped_write_gpio");
        bus_cycle(WE_NONE, 32'h0, 0, 1, 32'h1111_1111, "unmapped_write_ram");
        while (exp_q.size() > 0) begin
            logic [31:0] want, got;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: data_out=%h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_timer();
        pulse_reset(WE_NONE, 32'h0, 32'h0);
        bus_cycle(WE_WORD, TCMP_ADDR, 32'd20, 0, 0, "");
        bus_cycle(WE_NONE, TCMP_ADDR, 0, 1, 32'd20, "tcmp_read");
        for (int g = 0; g < 64 && cyc_model < 32'd20; g++)
            bus_cycle(WE_NONE, TSTAT_ADDR, 0, 1, 32'h0, "tstat_before_match");
        checks++;
        if (cyc_model !== 32'd20) begin
            failures++;
            $display("FAIL timer_sync: cycle=%0d want 20", cyc_model);
        end
        bus_cycle(WE_WORD, TSTAT_ADDR, 32'h1, 1, 32'h0, "tstat_on_match_edge");
        bus_cycle(WE_NONE, TSTAT_ADDR, 0, 1, 32'h1, "tstat_set_wins");
        bus_cycle(WE_WORD, TSTAT_ADDR, 32'hFFFF_FFFE, 1, 32'h1, "tstat_w0_ignored");
        bus_cycle(WE_WORD, TSTAT_ADDR, 32'h1, 1, 32'h1, "tstat_clear_edge");
        bus_cycle(WE_NONE, TSTAT_ADDR, 0, 1, 32'h0, "tstat_cleared");
        while (exp_q.size() > 0) begin
            logic [31:0] want, got;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: data_out=%h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_wrap();
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        bus_cycle(WE_NONE, CYCLE_ADDR, 0, 1, 32'hFFFF_FFFE, "wrap_fffe");
        bus_cycle(WE_NONE, CYCLE_ADDR, 0, 1, 32'hFFFF_FFFF, "wrap_ffff");
        bus_cycle(WE_NONE, CYCLE_ADDR, 0, 1, 32'h0000_0000, "wrap_zero");
        bus_cycle(WE_NONE, CYCLE_ADDR, 0, 1, 32'h0000_0001, "wrap_one");
        while (exp_q.size() > 0) begin
            logic [31:0] want, got;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: data_out=%h expected %h", tag, got, want);
            end
        end
    endtask

    initial begin
        bus.write_enable = WE_NONE;
        bus.addr         = '0;
        bus.data_in      = '0;
        @(negedge clk);
        test_reset();
        test_ram_store();
        test_ram_bounds();
        test_registers();
        test_reset_retention();
        test_timer();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
